// File: rtl/instr_fetch_if.sv
// Instruction-memory bus between the fetch stage and an asynchronous-read ROM/RAM.
interface instr_fetch_if;
  logic [10:0] imem_addr;
  logic [31:0] imem_instr;

  modport master (output imem_addr, input imem_instr);
  modport slave  (input imem_addr, output imem_instr);
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: PC register with redirect/stall/flush control and the IF/ID pipeline register.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [31:0] EXC_VEC  = 32'h0040_0004
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  input  logic                br_taken,
  input  logic [31:0]         br_target,
  input  logic                jmp,
  input  logic [31:0]         jmp_target,
  input  logic                exc,
  input  logic                eret,
  input  logic [31:0]         epc,
  instr_fetch_if.master       imem,
  output logic [31:0]         pc,
  output logic [31:0]         if_instr,
  output logic [31:0]         if_pc,
  output logic [31:0]         if_pc4,
  output logic                if_valid,
  output logic [31:0]         fetch_cnt
);

  logic        redirect;
  logic [31:0] redir_raw;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;

  // Word offset into the memory window; wraps modulo 2048 words.
  assign imem.imem_addr = 11'((pc - RESET_PC) >> 2);

  assign pc_plus4 = pc + 32'd4;
  assign redirect = exc | eret | jmp | br_taken;

  always_comb begin
    redir_raw = br_target;
    if (exc)       redir_raw = EXC_VEC;
    else if (eret) redir_raw = epc;
    else if (jmp)  redir_raw = jmp_target;

    pc_next = pc_plus4;
    if (redirect)   pc_next = redir_raw & ~32'h3;
    else if (stall) pc_next = pc;
  end

  // Flush only bubbles IF/ID; the PC follows the normal stall/sequential rule.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      if_instr  <= '0;
      if_pc     <= '0;
      if_pc4    <= '0;
      if_valid  <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      pc <= pc_next;
      if (redirect || flush) begin
        if_instr <= '0;
        if_valid <= 1'b0;
      end else if (!stall) begin
        if_instr  <= imem.imem_instr;
        if_pc     <= pc;
        if_pc4    <= pc_plus4;
        if_valid  <= 1'b1;
        fetch_cnt <= fetch_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed-vector bench for instr_fetch with an asynchronous-read instruction memory model.
module tb_instr_fetch;
  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst, stall, flush, br_taken, jmp, exc, eret;
  logic [31:0] br_target, jmp_target, epc;
  logic [31:0] pc, if_instr, if_pc, if_pc4, fetch_cnt;
  logic        if_valid;
  logic [31:0] mem [2048];

  instr_fetch_if ifc ();
  assign ifc.imem_instr = mem[ifc.imem_addr];

  instr_fetch #(.RESET_PC(32'h0040_0000), .EXC_VEC(32'h0040_0004)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .br_taken(br_taken), .br_target(br_target),
    .jmp(jmp), .jmp_target(jmp_target),
    .exc(exc), .eret(eret), .epc(epc),
    .imem(ifc.master),
    .pc(pc), .if_instr(if_instr), .if_pc(if_pc), .if_pc4(if_pc4),
    .if_valid(if_valid), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stall, flush, br, jmp, exc, eret;
    logic [31:0] brt, jt, epc;
    logic [31:0] e_pc, e_instr, e_ifpc, e_ifpc4, e_cnt;
    logic        e_valid;
    logic [10:0] e_addr;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input logic r, s, f, b, input logic [31:0] bt,
                     input logic j, input logic [31:0] jt,
                     input logic x, e, input logic [31:0] ep,
                     input logic [31:0] xpc, xin, xifpc, xifpc4,
                     input logic xv, input logic [31:0] xcnt, input logic [10:0] xaddr);
    vec_t v;
    v.rst = r; v.stall = s; v.flush = f; v.br = b; v.brt = bt;
    v.jmp = j; v.jt = jt; v.exc = x; v.eret = e; v.epc = ep;
    v.e_pc = xpc; v.e_instr = xin; v.e_ifpc = xifpc; v.e_ifpc4 = xifpc4;
    v.e_valid = xv; v.e_cnt = xcnt; v.e_addr = xaddr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h, expected %h", name, idx, got, exp);
    end
  endtask

  task automatic idle_inputs();
    rst = 0; stall = 0; flush = 0; br_taken = 0; jmp = 0; exc = 0; eret = 0;
    br_target = '0; jmp_target = '0; epc = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] m_pc, m_cnt, m_instr;
    for (int unsigned i = 0; i < 2048; i++) mem[i] = 32'hC0DE_0000 + i;
    idle_inputs();

    //   rst st fl br brt          jmp jt           exc er epc          pc           instr        ifpc         ifpc4        v  cnt addr
    add(1, 0, 0, 0, 0,            0, 0,            0, 0, 0,            32'h00400000, 32'h0,       32'h0,       32'h0,       0, 0, 11'h000);
    add(0, 0, 0, 0, 0,            0, 0,            0, 0, 0,            32'h00400004, 32'hC0DE0000,32'h00400000,32'h00400004,1, 1, 11'h001);
    add(0, 0, 0, 0, 0,            0, 0,            0, 0, 0,            32'h00400008, 32'hC0DE0001,32'h00400004,32'h00400008,1, 2, 11'h002);
    add(0, 0, 0, 0, 0,            0, 0,            0, 0, 0,            32'h0040000C, 32'hC0DE0002,32'h00400008,32'h0040000C,1, 3, 11'h003);
    add(1, 0, 0, 0, 0,            0, 0,            0, 0, 0,            32'h00400000, 32'h0,       32'h0,       32'h0,       0, 0, 11'h000);
    add(0, 0, 0, 0, 0,            0, 0,            0, 0, 0,            32'h00400004, 32'hC0DE0000,32'h00400000,32'h00400004,1, 1, 11'h001);
    add(0, 1, 0, 0, 0,            0, 0,            0, 0, 0,            32'h00400004, 32'hC0DE0000,32'h00400000,32'h00400004,1, 1, 11'h001);
    add(0, 1, 0, 0, 0,            0, 0,            0, 0, 0,            32'h00400004, 32'hC0DE0000,32'h00400000,32'h00400004,1, 1, 11'h001);
    add(0, 0, 0, 0, 0,            0, 0,            0, 0, 0,            32'h00400008, 32'hC0DE0001,32'h00400004,32'h00400008,1, 2, 11'h002);
    add(0, 0, 1, 0, 0,            0, 0,            0, 0, 0,            32'h0040000C, 32'h0,       32'h00400004,32'h00400008,0, 2, 11'h003);
    add(0, 1, 1, 0, 0,            0, 0,            0, 0, 0,            32'h0040000C, 32'h0,       32'h00400004,32'h00400008,0, 2, 11'h003);
    add(0, 1, 0, 1, 32'h00400103, 0, 0,            0, 0, 0,            32'h00400100, 32'h0,       32'h00400004,32'h00400008,0, 2, 11'h040);
    add(0, 0, 0, 0, 0,            0, 0,            0, 0, 0,            32'h00400104, 32'hC0DE0040,32'h00400100,32'h00400104,1, 3, 11'h041);
    add(0, 0, 0, 0, 0,            1, 32'h00400200, 1, 1, 32'h00400020, 32'h00400004, 32'h0,       32'h00400100,32'h00400104,0, 3, 11'h001);
    add(0, 0, 0, 0, 0,            0, 0,            0, 1, 32'h00400020, 32'h00400020, 32'h0,       32'h00400100,32'h00400104,0, 3, 11'h008);
    add(0, 0, 0, 1, 32'h00400500, 1, 32'h00400302, 0, 0, 0,            32'h00400300, 32'h0,       32'h00400100,32'h00400104,0, 3, 11'h0C0);
    add(0, 0, 0, 0, 0,            0, 0,            0, 0, 0,            32'h00400304, 32'hC0DE00C0,32'h00400300,32'h00400304,1, 4, 11'h0C1);
    add(0, 0, 0, 0, 0,            1, 32'h00401FFC, 0, 0, 0,            32'h00401FFC, 32'h0,       32'h00400300,32'h00400304,0, 4, 11'h7FF);
    add(0, 0, 0, 0, 0,            0, 0,            0, 0, 0,            32'h00402000, 32'hC0DE07FF,32'h00401FFC,32'h00402000,1, 5, 11'h000);
    add(0, 0, 0, 0, 0,            0, 0,            0, 0, 0,            32'h00402004, 32'hC0DE0000,32'h00402000,32'h00402004,1, 6, 11'h001);
    add(1, 1, 0, 0, 0,            1, 32'h00400200, 0, 0, 0,            32'h00400000, 32'h0,       32'h0,       32'h0,       0, 0, 11'h000);
    add(0, 0, 0, 0, 0,            0, 0,            0, 0, 0,            32'h00400004, 32'hC0DE0000,32'h00400000,32'h00400004,1, 1, 11'h001);
    add(0, 0, 1, 0, 0,            0, 0,            1, 0, 0,            32'h00400004, 32'h0,       32'h00400000,32'h00400004,0, 1, 11'h001);
    add(0, 0, 0, 0, 0,            0, 0,            0, 1, 32'h00400023, 32'h00400020, 32'h0,       32'h00400000,32'h00400004,0, 1, 11'h008);

    @(negedge clk);
    foreach (vecs[i]) begin
      rst = vecs[i].rst; stall = vecs[i].stall; flush = vecs[i].flush;
      br_taken = vecs[i].br; br_target = vecs[i].brt;
      jmp = vecs[i].jmp; jmp_target = vecs[i].jt;
      exc = vecs[i].exc; eret = vecs[i].eret; epc = vecs[i].epc;
      step();
      chk("pc",        i, pc,        vecs[i].e_pc);
      chk("if_instr",  i, if_instr,  vecs[i].e_instr);
      chk("if_pc",     i, if_pc,     vecs[i].e_ifpc);
      chk("if_pc4",    i, if_pc4,    vecs[i].e_ifpc4);
      chk("if_valid",  i, {31'b0, if_valid}, {31'b0, vecs[i].e_valid});
      chk("fetch_cnt", i, fetch_cnt, vecs[i].e_cnt);
      chk("imem_addr", i, {21'b0, ifc.imem_addr}, {21'b0, vecs[i].e_addr});
      @(negedge clk);
    end

    // Free-running run from pc 0x00400020 against a sequential model.
    idle_inputs();
    m_pc = 32'h0040_0020;
    m_cnt = 32'd1;
    for (int i = 0; i < 8; i++) begin
      m_instr = mem[11'((m_pc - RPC) >> 2)];
      step();
      chk("run_if_instr", i, if_instr, m_instr);
      chk("run_if_pc",    i, if_pc,    m_pc);
      m_pc  = m_pc + 32'd4;
      m_cnt = m_cnt + 32'd1;
      chk("run_pc",  i, pc,        m_pc);
      chk("run_cnt", i, fetch_cnt, m_cnt);
      @(negedge clk);
    end

    // Long stall: everything holds.
    stall = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_pc",    i, pc,        m_pc);
      chk("stall_cnt",   i, fetch_cnt, m_cnt);
      chk("stall_valid", i, {31'b0, if_valid}, 32'd1);
      @(negedge clk);
    end

    // Exception alone while stalled goes to the vector.
    exc = 1;
    step();
    chk("exc_pc",    0, pc, 32'h0040_0004);
    chk("exc_valid", 0, {31'b0, if_valid}, 32'd0);
    chk("exc_cnt",   0, fetch_cnt, m_cnt);
    @(negedge clk);
    idle_inputs();
    step();
    chk("after_exc_instr", 0, if_instr, mem[1]);
    chk("after_exc_cnt",   0, fetch_cnt, m_cnt + 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0040_0000, the PC value loaded on reset and the base of the instruction memory window.
REQ-002 SHALL provide parameter EXC_VEC, default 32'h0040_0004, the PC loaded on exception entry.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, reset; synchronous and active-high.
REQ-005 SHALL have port stall, input, 1 bit, a downstream hold request.
REQ-006 SHALL have port flush, input, 1 bit, which kills the instruction being captured this cycle.
REQ-007 SHALL have ports br_taken, input, 1 bit, and br_target, input, 32 bits, forming the branch redirect.
REQ-008 SHALL have ports jmp, input, 1 bit, and jmp_target, input, 32 bits, forming the jump redirect (j/jal/jr/jalr).
REQ-009 SHALL have port exc, input, 1 bit, the exception/syscall/break entry request.
REQ-010 SHALL have ports eret, input, 1 bit, and epc, input, 32 bits, forming the exception return.
REQ-011 SHALL have port imem_addr, output, 11 bits, the word address driven to the instruction memory.
REQ-012 SHALL have port imem_instr, input, 32 bits, the asynchronous-read data returned by the instruction memory for imem_addr in the same cycle.
REQ-013 SHALL have port pc, output, 32 bits, the current fetch PC.
REQ-014 SHALL have ports if_instr, if_pc and if_pc4, outputs, 32 bits each, forming the IF/ID pipeline register.
REQ-015 SHALL have port if_valid, output, 1 bit, which is high when the IF/ID register holds a real instruction.
REQ-016 SHALL have port fetch_cnt, output, 32 bits, the count of instructions captured into IF/ID.

Function
REQ-017 imem_addr SHALL be combinational: (pc - RESET_PC) >> 2, truncated to 11 bits, so addresses wrap modulo 2048 words with no error.
REQ-018 Next-PC priority SHALL be exc > eret > jmp > br_taken > stall > sequential (pc + 4, 32-bit wrap).
REQ-019 Redirect targets SHALL be EXC_VEC, epc, jmp_target or br_target respectively, each with bits [1:0] forced to 0.
REQ-020 Any redirect (exc, eret, jmp, br_taken) SHALL load the PC even when stall is high; a redirect overrides stall.
REQ-021 On a redirect edge, IF/ID SHALL load a bubble: if_instr = 0, if_valid = 0, and if_pc/if_pc4 hold their previous values.
REQ-022 With stall = 1 and no redirect, pc and all IF/ID outputs SHALL hold and fetch_cnt SHALL not change.
REQ-023 With flush = 1 and no redirect, pc SHALL advance per REQ-018 and IF/ID SHALL load a bubble; flush overrides stall for IF/ID only, so pc still holds under stall.
REQ-024 On a normal capture edge (no rst, redirect, stall or flush), the IF/ID register SHALL load as follows: if_instr = imem_instr, if_pc = pc, if_pc4 = pc + 4, if_valid = 1.
REQ-025 Fetch latency SHALL be one cycle: the instruction at PC appears on if_instr on the edge after pc shows that value.
REQ-026 fetch_cnt SHALL increment by 1 (wrapping at 2^32) on each edge where if_valid is loaded with 1.

Reset
REQ-027 When rst = 1 at an edge: pc = RESET_PC, if_instr = 0, if_pc = 0, if_pc4 = 0, if_valid = 0, fetch_cnt = 0; rst overrides every other input.
REQ-028 rst asserted mid-operation, including during stall or redirect, SHALL discard in-flight state with no residual capture on the following edge.
REQ-029 In the first cycle after reset deasserts, imem_addr SHALL be 0.

Verification
REQ-030 Reset, then 3 free-running cycles with mem[0..2] = A, B, C -> if_instr sequence A, B, C; if_pc sequence 0x00400000, 0x00400004, 0x00400008; fetch_cnt = 3.
REQ-031 stall held 2 cycles after the first capture -> pc = 0x00400004 and if_instr = A held for both cycles; fetch_cnt unchanged; then resumes with B.
REQ-032 br_taken = 1 with br_target = 0x00400103 while stall = 1 -> next pc = 0x00400100, if_valid = 0; next edge imem_addr = 0x040 and if_instr = mem[0x40].
REQ-033 exc, eret and jmp asserted in the same cycle -> pc = 0x00400004; then eret alone with epc = 0x00400020 -> pc = 0x00400020.
REQ-034 pc = 0x00401FFC (imem_addr 0x7FF) free-running -> next pc = 0x00402000 with imem_addr wrapping to 0x000.
REQ-035 rst asserted during a stall with jmp = 1 -> pc = 0x00400000, if_valid = 0, fetch_cnt = 0.
